wb_stage_gen: RTL and testbench
===============================

WB_STAGE_GEN -- requirements
Module: wb_stage_gen

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath/PC width; RADDR_W, default 5, register-address width; CSR_W, default 14, CSR-number width; CNT_W, default 32, retire-counter width; CSR_WAIT, default 1, 1 = honour csr_ready, 0 = ignore it.
REQ-002 SHALL have ports, as name / direction / width / meaning:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- mem_to_wb_valid  in  1  MEM holds a valid instruction
- wb_allowin  out  1  WB accepts a new instruction
- mem_pc  in  XLEN  instruction PC
- mem_rf_we, mem_rf_waddr, mem_rf_wdata  in  1/RADDR_W/XLEN  register write
- mem_csr_re, mem_csr_we  in  1/1  CSR read / write request
- mem_csr_num  in  CSR_W  CSR number
- mem_csr_wmask, mem_csr_wvalue  in  XLEN/XLEN  CSR write mask / value
- mem_ertn, mem_ex  in  1/1  ertn instruction / exception flag
- mem_ecode, mem_esubcode  in  6/9  exception codes
- csr_rvalue  in  XLEN  CSR read data
- csr_ready  in  1  CSR access completes this cycle
- csr_re, csr_we  out  1/1  CSR strobes
- csr_num  out  CSR_W  CSR number
- csr_wmask, csr_wvalue  out  XLEN/XLEN  CSR write mask / value
- rf_we, rf_waddr, rf_wdata  out  1/RADDR_W/XLEN  register-file write and ID forward
- wb_ex  out  1  exception commit
- wb_ecode, wb_esubcode  out  6/9  exception codes
- wb_ex_pc  out  XLEN  exception PC
- ertn_flush  out  1  ertn commit
- wb_flush  out  1  pipeline flush pulse
- retire_cnt  out  CNT_W  retired-instruction count
- debug_wb_pc  out  XLEN  commit PC
- debug_wb_rf_we  out  4  trace write enable
- debug_wb_rf_wnum  out  RADDR_W  trace register number
- debug_wb_rf_wdata  out  XLEN  trace write data

Function
REQ-003 SHALL latch all mem_* fields into WB registers when mem_to_wb_valid & wb_allowin & ~wb_flush.
- Fields SHALL hold when that condition is false.
REQ-004 SHALL update wb_valid only when wb_allowin:
- 0 if wb_flush
- else mem_to_wb_valid
REQ-005 SHALL define csr_access = wb_csr_re | wb_csr_we; ready_go = ~csr_access | csr_ready | (CSR_WAIT==0); wb_allowin = ~wb_valid | ready_go.
REQ-006 SHALL define commit = wb_valid & ready_go.
- Each held instruction commits exactly once.
- WB latency SHALL be 1 cycle when no CSR wait is needed.
REQ-007 SHALL hold csr_re, csr_we, csr_num, csr_wmask and csr_wvalue stable while a CSR access waits for csr_ready.
- csr_re = wb_valid & wb_csr_re & ~wb_ex_r.
- csr_we = commit & wb_csr_we & ~wb_ex_r; csr_we SHALL be asserted for exactly one cycle per instruction.
REQ-008 SHALL drive rf_we = commit & wb_rf_we & ~wb_ex_r, with rf_waddr = wb_rf_waddr.
- rf_wdata = csr_rvalue when wb_csr_re, else wb_rf_wdata.
REQ-009 SHALL drive the exception outputs as follows:
- wb_ex = commit & wb_ex_r; wb_ecode, wb_esubcode and wb_ex_pc = registered values.
- ertn_flush = commit & wb_ertn_r & ~wb_ex_r.
- wb_flush = wb_ex | ertn_flush.
REQ-010 SHALL, in a wb_flush cycle, discard any instruction offered by MEM.
- wb_valid SHALL be 0 in the next cycle.
REQ-011 SHALL increment retire_cnt by 1 on each commit with ~wb_ex_r, wrapping from 2^CNT_W-1 to 0.
REQ-012 SHALL drive the debug outputs as follows:
- debug_wb_rf_we = {4{rf_we}}.
- debug_wb_rf_wnum = rf_waddr; debug_wb_rf_wdata = rf_wdata.
- debug_wb_pc = wb_pc.
REQ-013 SHALL keep all committing outputs 0 when wb_valid=0, regardless of stale field values.
- Committing outputs: rf_we, csr_we, wb_ex, ertn_flush, wb_flush, debug_wb_rf_we.

Reset
REQ-014 SHALL, on resetn=0 at a clk edge, clear wb_valid, all field registers and retire_cnt.
- All outputs SHALL read 0 in the following cycle, and wb_allowin SHALL read 1.
REQ-015 SHALL treat reset asserted mid-CSR-wait as abandoning the instruction: no commit, no csr_we, and retire_cnt = 0.

Verification
REQ-016 Back-to-back ALU instructions: PCs 0x1c000000, 0x1c000004 with rf_we=1, waddr=4 and 5 -> one rf_we pulse per cycle, matching debug trace, retire_cnt ends at 2.
REQ-017 CSR read with CSR_WAIT=1, csr_ready low for 3 cycles: wb_allowin=0 for 3 cycles, a single rf_we whose rf_wdata=csr_rvalue=0xdeadbeef, next MEM instruction held.
REQ-018 Exception instruction (mem_ex=1, ecode=0x0b, rf_we=1): wb_ex=1 for one cycle, wb_ex_pc=PC, rf_we=0, wb_flush=1, the concurrently offered MEM instruction is dropped, retire_cnt unchanged.
REQ-019 ertn instruction: ertn_flush=1 and wb_flush=1 for one cycle, wb_ex=0, next cycle wb_valid=0.
REQ-020 Wrap: CNT_W=4, 17 retired instructions -> retire_cnt=1.
REQ-021 Reset during CSR wait -> no csr_we, and all outputs are 0 the following cycle.

Source files
------------

// File: rtl/wb_stage_gen.sv
// wb_stage_gen: writeback stage that commits register/CSR writes, raises exceptions and ertn flushes,
// and counts retired instructions.
module wb_stage_gen #(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int CSR_W    = 14,
  parameter int CNT_W    = 32,
  parameter int CSR_WAIT = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mem_to_wb_valid,
  output logic               wb_allowin,
  input  logic [XLEN-1:0]    mem_pc,
  input  logic               mem_rf_we,
  input  logic [RADDR_W-1:0] mem_rf_waddr,
  input  logic [XLEN-1:0]    mem_rf_wdata,
  input  logic               mem_csr_re,
  input  logic               mem_csr_we,
  input  logic [CSR_W-1:0]   mem_csr_num,
  input  logic [XLEN-1:0]    mem_csr_wmask,
  input  logic [XLEN-1:0]    mem_csr_wvalue,
  input  logic               mem_ertn,
  input  logic               mem_ex,
  input  logic [5:0]         mem_ecode,
  input  logic [8:0]         mem_esubcode,
  input  logic [XLEN-1:0]    csr_rvalue,
  input  logic               csr_ready,
  output logic               csr_re,
  output logic               csr_we,
  output logic [CSR_W-1:0]   csr_num,
  output logic [XLEN-1:0]    csr_wmask,
  output logic [XLEN-1:0]    csr_wvalue,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               wb_ex,
  output logic [5:0]         wb_ecode,
  output logic [8:0]         wb_esubcode,
  output logic [XLEN-1:0]    wb_ex_pc,
  output logic               ertn_flush,
  output logic               wb_flush,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [XLEN-1:0]    debug_wb_pc,
  output logic [3:0]         debug_wb_rf_we,
  output logic [RADDR_W-1:0] debug_wb_rf_wnum,
  output logic [XLEN-1:0]    debug_wb_rf_wdata
);
  localparam bit NO_WAIT = (CSR_WAIT == 0);
  logic               wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]    pc_q;
  logic               rf_we_q;
  logic [RADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]    rf_wdata_q;
  logic               csr_re_q, csr_we_q;
  logic [CSR_W-1:0]   csr_num_q;
  logic [XLEN-1:0]    csr_wmask_q, csr_wvalue_q;
  logic               ertn_q, ex_q;
  logic [5:0]         ecode_q;
  logic [8:0]         esubcode_q;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic               ready_go, commit, load;
  assign ready_go     = ~(csr_re_q | csr_we_q) | csr_ready | NO_WAIT;
  assign commit       = wb_valid_q & ready_go;
  assign wb_allowin   = ~wb_valid_q | ready_go;
  assign load         = mem_to_wb_valid & wb_allowin & ~wb_flush;
  assign wb_valid_d   = wb_allowin ? (mem_to_wb_valid & ~wb_flush) : wb_valid_q;
  assign retire_cnt_d = retire_cnt_q + CNT_W'(commit & ~ex_q);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid_q   <= 1'b0;
      retire_cnt_q <= '0;
      pc_q         <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      csr_re_q     <= 1'b0;
      csr_we_q     <= 1'b0;
      csr_num_q    <= '0;
      csr_wmask_q  <= '0;
      csr_wvalue_q <= '0;
      ertn_q       <= 1'b0;
      ex_q         <= 1'b0;
      ecode_q      <= '0;
      esubcode_q   <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      retire_cnt_q <= retire_cnt_d;
      if (load) begin
        pc_q         <= mem_pc;
        rf_we_q      <= mem_rf_we;
        rf_waddr_q   <= mem_rf_waddr;
        rf_wdata_q   <= mem_rf_wdata;
        csr_re_q     <= mem_csr_re;
        csr_we_q     <= mem_csr_we;
        csr_num_q    <= mem_csr_num;
        csr_wmask_q  <= mem_csr_wmask;
        csr_wvalue_q <= mem_csr_wvalue;
        ertn_q       <= mem_ertn;
        ex_q         <= mem_ex;
        ecode_q      <= mem_ecode;
        esubcode_q   <= mem_esubcode;
      end
    end
  end
  // CSR strobes come straight from held fields, so they stay stable across a wait
  assign csr_re     = wb_valid_q & csr_re_q & ~ex_q;
  assign csr_we     = commit & csr_we_q & ~ex_q;
  assign csr_num    = csr_num_q;
  assign csr_wmask  = csr_wmask_q;
  assign csr_wvalue = csr_wvalue_q;
  assign rf_we      = commit & rf_we_q & ~ex_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = csr_re_q ? csr_rvalue : rf_wdata_q;
  assign wb_ex       = commit & ex_q;
  assign wb_ecode    = ecode_q;
  assign wb_esubcode = esubcode_q;
  assign wb_ex_pc    = pc_q;
  assign ertn_flush  = commit & ertn_q & ~ex_q;
  assign wb_flush    = wb_ex | ertn_flush;
  assign retire_cnt  = retire_cnt_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_stage_gen.sv
// tb_wb_stage_gen: directed and random checks of wb_stage_gen against an instruction-level model
// (4-bit retire counter so wrap-around is reachable).
module tb_wb_stage_gen;
  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_re, csr_we;
    logic [13:0] num;
    logic [31:0] wmask, wvalue;
    logic        ertn, ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
  } ins_t;
  logic clk = 1'b0, resetn = 1'b0, in_v = 1'b0, rdy = 1'b0;
  logic [31:0] rval = '0;
  ins_t m_in = '0;
  logic wb_allowin, csr_re, csr_we, rf_we, wb_ex, ertn_flush, wb_flush;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, rf_wdata, wb_ex_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [3:0]  retire_cnt, debug_wb_rf_we;
  int vecs = 0, errs = 0;
  bit chk_en = 0;
  bit mv = 0;
  ins_t mi = '0;
  int mcnt = 0;
  always #5 clk = ~clk;
  wb_stage_gen #(.XLEN(32), .RADDR_W(5), .CSR_W(14), .CNT_W(4), .CSR_WAIT(1)) dut (
    .clk(clk), .resetn(resetn), .mem_to_wb_valid(in_v), .wb_allowin(wb_allowin),
    .mem_pc(m_in.pc), .mem_rf_we(m_in.rf_we), .mem_rf_waddr(m_in.waddr), .mem_rf_wdata(m_in.wdata),
    .mem_csr_re(m_in.csr_re), .mem_csr_we(m_in.csr_we), .mem_csr_num(m_in.num),
    .mem_csr_wmask(m_in.wmask), .mem_csr_wvalue(m_in.wvalue), .mem_ertn(m_in.ertn), .mem_ex(m_in.ex),
    .mem_ecode(m_in.ecode), .mem_esubcode(m_in.esub), .csr_rvalue(rval), .csr_ready(rdy),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_ex_pc(wb_ex_pc), .ertn_flush(ertn_flush), .wb_flush(wb_flush),
    .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // The held instruction retires once its CSR access (if any) sees csr_ready
  function automatic bit done_now();
    return mv && (!(mi.csr_re || mi.csr_we) || rdy);
  endfunction
  task automatic check_all();
    bit done, good;
    logic [31:0] wd;
    done = done_now();
    good = done && !mi.ex;
    wd = mi.csr_re ? rval : mi.wdata;
    chk("allowin", wb_allowin, !mv || !(mi.csr_re || mi.csr_we) || rdy);
    chk("csr_re", csr_re, mv && mi.csr_re && !mi.ex);
    chk("csr_we", csr_we, good && mi.csr_we);
    chk("csr_num", csr_num, mi.num);
    chk("csr_wmask", csr_wmask, mi.wmask);
    chk("csr_wvalue", csr_wvalue, mi.wvalue);
    chk("rf_we", rf_we, good && mi.rf_we);
    chk("rf_waddr", rf_waddr, mi.waddr);
    chk("rf_wdata", rf_wdata, wd);
    chk("wb_ex", wb_ex, done && mi.ex);
    chk("wb_ecode", wb_ecode, mi.ecode);
    chk("wb_esubcode", wb_esubcode, mi.esub);
    chk("wb_ex_pc", wb_ex_pc, mi.pc);
    chk("ertn_flush", ertn_flush, good && mi.ertn);
    chk("wb_flush", wb_flush, done && (mi.ex || mi.ertn));
    chk("retire_cnt", retire_cnt, mcnt % 16);
    chk("dbg_pc", debug_wb_pc, mi.pc);
    chk("dbg_we", debug_wb_rf_we, (good && mi.rf_we) ? 4'hf : 4'h0);
    chk("dbg_wnum", debug_wb_rf_wnum, mi.waddr);
    chk("dbg_wdata", debug_wb_rf_wdata, wd);
  endtask
  task automatic cyc(input bit rn, input bit v, input ins_t ins, input bit r, input logic [31:0] rv);
    resetn = rn; in_v = v; m_in = ins; rdy = r; rval = rv;
    @(negedge clk);
    if (chk_en) check_all();
  endtask
  task automatic tick();
    bit done, flush, allow;
    done = done_now();
    flush = done && (mi.ex || mi.ertn);
    allow = !mv || !(mi.csr_re || mi.csr_we) || rdy;
    @(posedge clk);
    if (!resetn) begin
      mv = 0; mi = '0; mcnt = 0;
    end else begin
      if (done && !mi.ex) mcnt++;
      if (allow) begin
        if (in_v && !flush) mi = m_in;
        mv = in_v && !flush;
      end
    end
    chk_en = 1;
    #1;
  endtask
  task automatic step(input bit rn, input bit v, input ins_t ins, input bit r, input logic [31:0] rv);
    cyc(rn, v, ins, r, rv);
    tick();
  endtask
  function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    ins_t t = '0;
    t.pc = pc; t.rf_we = 1; t.waddr = wa; t.wdata = wd;
    return t;
  endfunction
  initial begin
    ins_t t, u;
    step(0, 0, '0, 0, 0);
    cyc(0, 1, alu(32'h1c000000, 4, 32'h11), 0, 0);
    chk("rst_allowin", wb_allowin, 1);
    tick();
    // back-to-back ALU
    step(1, 1, alu(32'h1c000000, 4, 32'h11), 0, 0);
    cyc(1, 1, alu(32'h1c000004, 5, 32'h22), 0, 0);
    chk("b2b_wnum0", debug_wb_rf_wnum, 4);
    tick();
    cyc(1, 0, '0, 0, 0);
    chk("b2b_we1", rf_we, 1);
    tick();
    cyc(1, 0, '0, 0, 0);
    chk("b2b_cnt", retire_cnt, 2);
    tick();
    // CSR read waiting three cycles for csr_ready
    t = alu(32'h1c000008, 7, 32'h5555); t.csr_re = 1; t.num = 14'h5;
    step(1, 1, t, 0, 0);
    u = alu(32'h1c00000c, 8, 32'h66);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, u, 0, 32'h12345678);
      chk("csr_wait_allowin", wb_allowin, 0);
      tick();
    end
    cyc(1, 1, u, 1, 32'hdeadbeef);
    chk("csr_rdata", rf_wdata, 32'hdeadbeef);
    tick();
    cyc(1, 0, '0, 0, 0);
    chk("held_next_waddr", rf_waddr, 8);
    tick();
    // exception drops the concurrently offered instruction
    t = alu(32'h1c000010, 9, 32'h77); t.ex = 1; t.ecode = 6'h0b;
    step(1, 1, t, 0, 0);
    cyc(1, 1, alu(32'h1c000014, 10, 32'h88), 0, 0);
    chk("ex_pulse", wb_ex, 1);
    chk("ex_pc", wb_ex_pc, 32'h1c000010);
    tick();
    step(1, 0, '0, 0, 0);
    // ertn
    t = '0; t.pc = 32'h1c000020; t.ertn = 1;
    step(1, 1, t, 0, 0);
    cyc(1, 1, alu(32'h1c000024, 11, 32'h99), 0, 0);
    chk("ertn_flush", ertn_flush, 1);
    tick();
    step(1, 0, '0, 0, 0);
    // reset while a CSR write waits
    t = alu(32'h1c000030, 12, 32'haa); t.csr_we = 1; t.num = 14'h40; t.wmask = '1; t.wvalue = 32'hcafe;
    step(1, 1, t, 0, 0);
    step(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    chk("rst_wait_csr_we", csr_we, 0);
    tick();
    cyc(1, 0, '0, 1, 0);
    chk("rst_wait_cnt", retire_cnt, 0);
    chk("rst_wait_pc", debug_wb_pc, 0);
    tick();
    // 17 retirements wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) step(1, 1, alu(32'h1c001000 + 4 * i, 5'(i), i), 0, 0);
    step(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    chk("wrap_cnt", retire_cnt, 1);
    tick();
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      t.pc = $urandom; t.wdata = $urandom; t.wmask = $urandom; t.wvalue = $urandom;
      t.csr_re = ($urandom % 4) == 0;
      t.csr_we = ($urandom % 4) == 0;
      t.ex = ($urandom % 8) == 0;
      t.ertn = ($urandom % 8) == 0;
      step(($urandom % 64) != 0, $urandom % 2, t, $urandom % 2, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
